// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/branch/memory-stall controller with timeout halt and
// saturating performance counters for freeze and branch-taken events.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_req,
  input  logic [31:0]      branch_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze,
  output logic             bubble,
  output logic             flush,
  output logic             stall_all,
  output logic             Branch_taken,
  output logic [31:0]      BranchAddr,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_cnt_nxt;
  logic             r_mem_error;
  logic             w_mem_error_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_mem_block;

  assign w_mem_block = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mem_error <= w_mem_error_nxt;
    end
  end

  // Control outputs are combinational; reset level gates them so nothing leaks while rst is low.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = 8'd0;
    w_mem_error_nxt = r_mem_error;
    freeze          = 1'b0;
    bubble          = 1'b0;
    flush           = 1'b0;
    stall_all       = 1'b0;
    Branch_taken    = 1'b0;
    BranchAddr      = 32'd0;
    if (rst) begin
      case (r_state)
        RUN: begin
          if (w_mem_block) begin
            stall_all = 1'b1;
            freeze    = 1'b1;
            if (r_wait_cnt == WAIT_LIMIT) begin
              w_state_nxt     = HALT;
              w_mem_error_nxt = 1'b1;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
          end else if (branch_req) begin
            Branch_taken = 1'b1;
            flush        = 1'b1;
            BranchAddr   = branch_target;
          end else if (hazard) begin
            freeze = 1'b1;
            bubble = 1'b1;
          end
        end
        HALT: begin
          stall_all = 1'b1;
          freeze    = 1'b1;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (cnt_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (freeze && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (Branch_taken && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign mem_error    = r_mem_error;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hazard = 1'b0;
  logic             branch_req = 1'b0;
  logic [31:0]      branch_target = 32'd0;
  logic             mem_req = 1'b0;
  logic             mem_ready = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             freeze, bubble, flush, stall_all, Branch_taken, mem_error;
  logic [31:0]      BranchAddr;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_halted;
  int m_waits;
  bit m_err;
  int m_stall;
  int m_flush;

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_req(branch_req),
    .branch_target(branch_target), .mem_req(mem_req), .mem_ready(mem_ready),
    .cnt_clr(cnt_clr), .freeze(freeze), .bubble(bubble), .flush(flush),
    .stall_all(stall_all), .Branch_taken(Branch_taken), .BranchAddr(BranchAddr),
    .mem_error(mem_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freeze"},  32'(freeze), 0);
    chk({tag, "_bubble"},  32'(bubble), 0);
    chk({tag, "_flush"},   32'(flush), 0);
    chk({tag, "_stall"},   32'(stall_all), 0);
    chk({tag, "_btaken"},  32'(Branch_taken), 0);
    chk({tag, "_baddr"},   BranchAddr, 0);
    chk({tag, "_memerr"},  32'(mem_error), 0);
    chk({tag, "_stcnt"},   32'(stall_cycles), 0);
    chk({tag, "_flcnt"},   32'(flush_count), 0);
  endtask

  // Assert reset with arbitrary inputs, hold it across an edge, release after the edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    hazard = 1'($urandom); branch_req = 1'($urandom); mem_req = 1'($urandom);
    mem_ready = 1'($urandom); cnt_clr = 1'($urandom); branch_target = $urandom;
    #2;
    chk_all_zero({tag, "_rstlow"});
    m_halted = 0; m_waits = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    chk_all_zero({tag, "_rstedge"});
    rst = 1'b1;
    hazard = 0; branch_req = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0; branch_target = 0;
  endtask

  // One clock cycle: apply inputs, check combinational controls mid-cycle,
  // advance the model, then check registered outputs after the edge.
  task automatic cycle(input string tag, input logic h, input logic b, input logic [31:0] bt,
                       input logic mr, input logic mrdy, input logic clr);
    bit e_fr, e_bu, e_fl, e_st, e_bt;
    logic [31:0] e_ba;
    bit blocked;
    hazard = h; branch_req = b; branch_target = bt; mem_req = mr; mem_ready = mrdy; cnt_clr = clr;
    @(negedge clk);
    blocked = mr && !mrdy;
    e_fr = 0; e_bu = 0; e_fl = 0; e_st = 0; e_bt = 0; e_ba = 0;
    if (m_halted || blocked) begin
      e_st = 1; e_fr = 1;
    end else if (b) begin
      e_bt = 1; e_fl = 1; e_ba = bt;
    end else if (h) begin
      e_fr = 1; e_bu = 1;
    end
    chk({tag, "_freeze"}, 32'(freeze), 32'(e_fr));
    chk({tag, "_bubble"}, 32'(bubble), 32'(e_bu));
    chk({tag, "_flush"},  32'(flush), 32'(e_fl));
    chk({tag, "_stall"},  32'(stall_all), 32'(e_st));
    chk({tag, "_btaken"}, 32'(Branch_taken), 32'(e_bt));
    chk({tag, "_baddr"},  BranchAddr, e_ba);
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e_fr && m_stall < CNT_MAX) m_stall++;
      if (e_bt && m_flush < CNT_MAX) m_flush++;
    end
    if (!m_halted) begin
      if (blocked) begin
        m_waits++;
        if (m_waits == MEM_TIMEOUT) begin
          m_halted = 1; m_err = 1;
        end
      end else begin
        m_waits = 0;
      end
    end
    @(posedge clk); #1;
    chk({tag, "_memerr"}, 32'(mem_error), 32'(m_err));
    chk({tag, "_stcnt"},  32'(stall_cycles), 32'(m_stall));
    chk({tag, "_flcnt"},  32'(flush_count), 32'(m_flush));
  endtask

  initial begin
    do_reset("init");

    // Two-cycle hazard
    cycle("haz1", 1, 0, 0, 0, 0, 0);
    cycle("haz2", 1, 0, 0, 0, 0, 0);
    chk("haz_stall2", 32'(stall_cycles), 2);

    // Branch beats hazard
    cycle("br", 1, 1, 32'h40, 0, 0, 0);
    chk("br_flcnt1", 32'(flush_count), 1);

    // Three blocked cycles, then completion with a branch: no halt
    do_reset("r38");
    cycle("mw1", 0, 0, 0, 1, 0, 0);
    cycle("mw2", 0, 0, 0, 1, 0, 0);
    cycle("mw3", 0, 1, 32'h1234, 1, 0, 0);
    cycle("mw_done", 0, 1, 32'h1234, 1, 1, 0);
    chk("mw_noerr", 32'(mem_error), 0);

    // Wait count must clear after a non-blocked cycle
    cycle("wc1", 0, 0, 0, 1, 0, 0);
    cycle("wc2", 0, 0, 0, 1, 0, 0);
    cycle("wc3", 0, 0, 0, 1, 0, 0);
    cycle("wc_gap", 1, 0, 0, 0, 0, 0);
    cycle("wc4", 0, 0, 0, 1, 0, 0);
    chk("wc_noerr", 32'(mem_error), 0);

    // Ready on the limit cycle prevents halt
    do_reset("r28");
    cycle("lim1", 0, 0, 0, 1, 0, 0);
    cycle("lim2", 0, 0, 0, 1, 0, 0);
    cycle("lim3", 0, 0, 0, 1, 0, 0);
    cycle("lim_rdy", 1, 0, 0, 1, 1, 0);
    chk("lim_noerr", 32'(mem_error), 0);

    // Timeout into HALT
    do_reset("r39");
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle("to", 0, 0, 0, 1, 0, 0);
    chk("to_err", 32'(mem_error), 1);
    cycle("halt_rdy", 1, 1, 32'hDEAD, 1, 1, 0);
    chk("halt_stall", 32'(stall_all), 1);
    cycle("halt_clr", 0, 1, 32'h8, 0, 0, 1);
    chk("halt_err_kept", 32'(mem_error), 1);
    do_reset("halt_abort");
    cycle("post_halt", 0, 1, 32'h80, 0, 0, 0);

    // Saturation of stall counter, then clear overriding increment
    do_reset("r40");
    for (int i = 0; i < 20; i++) cycle("sat", 1, 0, 0, 0, 0, 0);
    chk("sat_max", 32'(stall_cycles), 32'hF);
    cycle("sat_clr", 1, 0, 0, 0, 0, 1);
    chk("sat_clr0", 32'(stall_cycles), 0);
    cycle("sat_after", 1, 0, 0, 0, 0, 0);
    chk("sat_after1", 32'(stall_cycles), 1);
    for (int i = 0; i < 20; i++) cycle("fsat", 0, 1, $urandom, 0, 0, 0);
    chk("fsat_max", 32'(flush_count), 32'hF);

    // Random traffic
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset("rnd_rst");
      cycle("rnd", 1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom,
            1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max consecutive memory-wait cycles before halt (legal 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 hazard  input  1  RAW hazard detected for the instruction in ID.
REQ-006 branch_req  input  1  EXE resolves a taken branch this cycle.
REQ-007 branch_target  input  32  branch destination from EXE.
REQ-008 mem_req  input  1  MEM stage issues a read/write this cycle.
REQ-009 mem_ready  input  1  memory completes the current access this cycle.
REQ-010 cnt_clr  input  1  synchronous clear of performance counters.
REQ-011 freeze  output  1  hold PC and IF/ID register.
REQ-012 bubble  output  1  load NOP into ID/EXE register.
REQ-013 flush  output  1  clear IF/ID and ID/EXE registers.
REQ-014 stall_all  output  1  hold every pipeline register (memory wait).
REQ-015 Branch_taken  output  1  select BranchAddr as next PC.
REQ-016 BranchAddr  output  32  next-PC value on branch.
REQ-017 mem_error  output  1  sticky memory-timeout flag.
REQ-018 stall_cycles  output  CNT_W  cycles with freeze=1.
REQ-019 flush_count  output  CNT_W  branches taken.

Function
REQ-020 SHALL implement states RUN, HALT plus a wait counter wait_cnt (8 bits); mem_block = mem_req & ~mem_ready.
REQ-021 In RUN, control outputs SHALL be combinational, same cycle, with strict priority: mem_block > branch_req > hazard > none.
REQ-022 mem_block: stall_all=1, freeze=1, bubble=0, flush=0, Branch_taken=0.
REQ-023 branch_req (no mem_block): Branch_taken=1, flush=1, BranchAddr=branch_target, freeze=0, bubble=0; hazard ignored.
REQ-024 hazard only: freeze=1, bubble=1, others 0.
REQ-025 None: all control outputs 0; BranchAddr SHALL be 0 whenever Branch_taken=0.
REQ-026 wait_cnt SHALL increment each cycle mem_block=1 in RUN and clear to 0 in any cycle mem_block=0.
REQ-027 mem_block with wait_cnt==MEM_TIMEOUT-1 SHALL transition to HALT and set mem_error next edge.
REQ-028 mem_ready=1 on the same cycle as that limit SHALL take precedence: no halt, wait_cnt cleared.
REQ-029 HALT: stall_all=1, freeze=1, all other control outputs 0, independent of inputs; exit only by reset.
REQ-030 stall_cycles SHALL increment on each edge where freeze=1, saturating at all-ones.
REQ-031 flush_count SHALL increment on each edge where Branch_taken=1, saturating at all-ones.
REQ-032 cnt_clr SHALL zero both counters next edge, overriding increment that cycle; does not affect state, wait_cnt, mem_error.

Reset
REQ-033 rst=0 SHALL immediately force state RUN, wait_cnt 0, mem_error 0, stall_cycles 0, flush_count 0.
REQ-034 While rst=0 every output SHALL be 0 regardless of inputs, including BranchAddr.
REQ-035 Reset asserted in HALT or mid memory wait SHALL abort it; first edge after release operates in RUN.

Verification
REQ-036 hazard=1 for 2 cycles, others 0 -> freeze=bubble=1 both cycles; stall_cycles=2.
REQ-037 branch_req=1, hazard=1, branch_target=0x00000040 -> Branch_taken=1, flush=1, BranchAddr=0x40, freeze=0; flush_count=1.
REQ-038 mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 with branch_req=1 -> stall_all=1 for 3 cycles, then Branch_taken=1, stall_all=0, no halt.
REQ-039 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> HALT after 4th blocked edge, mem_error=1, stall_all stays 1 after mem_ready=1; rst low -> all 0.
REQ-040 CNT_W=4, hazard held 20 cycles -> stall_cycles saturates at 0xF; cnt_clr with hazard=1 -> 0 next edge, 1 after following edge.
